// File: rtl/beep_scheduler.sv
// beep_scheduler: shares one passive buzzer among N_REQ requesters.
// Request pulses are latched as pending flags with a per-requester beep count.
// Pending requesters are granted round-robin; each grant plays a burst of
// beeps (tone ON phase, silent OFF phase) and ends with a one-cycle DONE.
// Optional feature macro: BEEP_PREEMPT_EN (requester 0 preempts other bursts).
module beep_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TONE_DIV  = 12500,
  parameter int unsigned UNIT_CYC  = 5000000,
  parameter int unsigned ON_UNITS  = 1,
  parameter int unsigned OFF_UNITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_cnt,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               done,
  output logic               beep
);

  localparam int unsigned ON_T   = ON_UNITS * UNIT_CYC;
  localparam int unsigned OFF_T  = OFF_UNITS * UNIT_CYC;
  localparam int unsigned PH_MAX = (ON_T > OFF_T) ? ON_T : OFF_T;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned TW     = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [PW-1:0] ON_LAST   = PW'(ON_T - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_T - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [N_REQ-1:0] pend_q, pend_d, pend_clr;
  logic [3:0]       cnt_lat_q [N_REQ];
  logic [3:0]       cnt_lat_d [N_REQ];
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    win_q;
  logic [3:0]       left_q;
  logic [PW-1:0]    ph_q;
  logic [TW-1:0]    tone_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic             done_q;
  logic             beep_q;

  logic             win_any;
  logic [IW-1:0]    win_idx;
  logic             preempt;

  // Round-robin search: first pending requester at or above rr_q, wrapping.
  always_comb begin : arb
    int unsigned pos;
    pos     = 0;
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(rr_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!win_any && pend_q[IW'(pos)]) begin
        win_any = 1'b1;
        win_idx = IW'(pos);
      end
    end
`ifdef BEEP_PREEMPT_EN
    // Requester 0 is served first once it has forced an abort, regardless of rr_q.
    if (pend_q[0]) win_idx = '0;
`endif
  end

  // Abort request for the burst in progress (only meaningful in ON/OFF).
  always_comb begin
    preempt = 1'b0;
`ifdef BEEP_PREEMPT_EN
    preempt = pend_q[0] && (win_q != '0);
`endif
  end

  // Pending flags and latched counts; a new request in the DONE cycle beats the clear.
  always_comb begin
    pend_clr = '0;
    if (state_q == S_DONE) pend_clr[win_q] = 1'b1;
    pend_d = (pend_q & ~pend_clr) | req;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cnt_lat_d[i] = req[i] ? req_cnt[4*i +: 4] : cnt_lat_q[i];
    end
  end

  // Pending register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) cnt_lat_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int unsigned i = 0; i < N_REQ; i++) cnt_lat_q[i] <= cnt_lat_d[i];
    end
  end

  // Burst sequencer with registered grant/busy/done/beep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      left_q  <= '0;
      ph_q    <= '0;
      tone_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_any) begin
            win_q   <= win_idx;
            grant_q <= N_REQ'(1) << win_idx;
            busy_q  <= 1'b1;
            left_q  <= cnt_lat_q[win_idx];
            ph_q    <= '0;
            tone_q  <= '0;
            if (cnt_lat_q[win_idx] == 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              beep_q  <= 1'b0;
            end else begin
              state_q <= S_ON;
              beep_q  <= 1'b1;
            end
          end
        end

        S_ON: begin
          if (preempt) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            beep_q  <= 1'b0;
            ph_q    <= '0;
            tone_q  <= '0;
          end else if (ph_q == ON_LAST) begin
            state_q <= S_OFF;
            beep_q  <= 1'b0;
            left_q  <= left_q - 1'b1;
            ph_q    <= '0;
            tone_q  <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
            if (tone_q == TONE_LAST) begin
              tone_q <= '0;
              beep_q <= ~beep_q;
            end else begin
              tone_q <= tone_q + 1'b1;
            end
          end
        end

        S_OFF: begin
          if (preempt) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            beep_q  <= 1'b0;
            ph_q    <= '0;
            tone_q  <= '0;
          end else if (ph_q == OFF_LAST) begin
            ph_q   <= '0;
            tone_q <= '0;
            if (left_q != 4'd0) begin
              state_q <= S_ON;
              beep_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          beep_q  <= 1'b0;
          rr_q    <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          beep_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign beep  = beep_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Bench for beep_scheduler: directed scenarios, a schedule-level reference
// model compared every cycle, and literal expectations for burst shapes.
module tb_beep_scheduler;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned TONE_DIV  = 4;
  localparam int unsigned UNIT_CYC  = 20;
  localparam int unsigned ON_UNITS  = 2;
  localparam int unsigned OFF_UNITS = 1;
  localparam int ON_T = ON_UNITS * UNIT_CYC;
  localparam int PER  = ON_T + OFF_UNITS * UNIT_CYC;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_cnt;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic        beep;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beep_scheduler #(
    .N_REQ    (N_REQ),
    .TONE_DIV (TONE_DIV),
    .UNIT_CYC (UNIT_CYC),
    .ON_UNITS (ON_UNITS),
    .OFF_UNITS(OFF_UNITS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_cnt(req_cnt),
    .grant  (grant),
    .busy   (busy),
    .done   (done),
    .beep   (beep)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, round-robin pointer, and the active burst
  // described by (winner, beep count, start cycle); outputs follow by arithmetic.
  bit [3:0] m_pend;
  int       m_cnt [4];
  int       m_rr, m_win, m_n, m_start, m_cyc;
  bit       m_active;

  task automatic m_reset();
    m_pend   = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_rr     = 0;
    m_win    = 0;
    m_n      = 0;
    m_start  = 0;
    m_cyc    = 0;
    m_active = 1'b0;
  endtask

  task automatic m_edge();
    bit [3:0] old;
    int o, w;
    old = m_pend;
    if (m_active) begin
      o = m_cyc - m_start;
      if (o == m_n * PER) begin
        m_pend[2'(m_win)] = 1'b0;
        m_rr     = (m_win + 1) % N_REQ;
        m_active = 1'b0;
      end
`ifdef BEEP_PREEMPT_EN
      else if (m_win != 0 && old[0]) m_active = 1'b0;
`endif
    end else if (old != 0) begin
      w = -1;
`ifdef BEEP_PREEMPT_EN
      if (old[0]) w = 0;
`endif
      for (int k = 0; k < 4; k++)
        if (w < 0 && old[2'((m_rr + k) % N_REQ)]) w = (m_rr + k) % N_REQ;
      m_win    = w;
      m_n      = m_cnt[2'(w)];
      m_start  = m_cyc + 1;
      m_active = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (req[2'(i)] === 1'b1) begin
        m_pend[2'(i)] = 1'b1;
        m_cnt[2'(i)]  = int'(req_cnt[4*i +: 4]);
      end
    end
    m_cyc++;
  endtask

  function automatic logic [6:0] m_out();
    logic [3:0] g;
    logic d, b;
    int o, ph;
    if (!m_active) return '0;
    o  = m_cyc - m_start;
    ph = o % PER;
    g  = 4'(1) << m_win;
    d  = (o == m_n * PER);
    b  = (o < m_n * PER) && (ph < ON_T) && (((ph / TONE_DIV) % 2) == 0);
    return {g, 1'b1, d, b};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_edge();
    end
  end

  bit chk_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check("cycle{grant,busy,done,beep}", {grant, busy, done, beep}, m_out());
    end
  end

  task automatic pulse(input logic [3:0] r, input logic [15:0] c);
    @(negedge clk);
    req     = r;
    req_cnt = c;
    @(negedge clk);
    req     = '0;
    req_cnt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts from the current negedge until busy drops.
  task automatic measure(output int nb, output int nh, output int nd, output int nm);
    nb = 0; nh = 0; nd = 0; nm = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy !== 1'b1) break;
      nb++;
      if (beep === 1'b1) nh++;
      if (done === 1'b1) nd++;
      if ($countones(grant) > 1) nm++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0 && m_pend == 0 && !m_active) break;
      @(negedge clk);
    end
    check("idle_wait_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    int nb, nh, nd, nm;
    rst = 1'b1; req = '0; req_cnt = '0;
    repeat (2) @(negedge clk);
    check("reset_grant", {28'd0, grant}, 0);
    check("reset_flags", {29'd0, busy, done, beep}, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // 1: single requester, two beeps
    pulse(4'b0010, 16'h0020);
    check("s1_idle_after_req", {27'd0, grant, busy}, 0);
    @(negedge clk);
    check("s1_grant", {28'd0, grant}, 32'b0010);
    check("s1_busy_beep", {30'd0, busy, beep}, 32'b11);
    measure(nb, nh, nd, nm);
    check("s1_busy_cycles", nb, 121);
    check("s1_beep_high", nh, 40);
    check("s1_done", nd, 1);
    check("s1_onehot", nm, 0);
    wait_idle(10);

    // 2: two simultaneous requests, rr_ptr=0
    do_reset();
    pulse(4'b0101, 16'h0101);
    @(negedge clk);
    check("s2_first_grant", {28'd0, grant}, 32'b0001);
    measure(nb, nh, nd, nm);
    check("s2_a_busy", nb, 61);
    check("s2_a_high", nh, 20);
    check("s2_a_done", nd, 1);
    check("s2_gap", {27'd0, grant, beep}, 0);
    @(negedge clk);
    check("s2_second_grant", {28'd0, grant}, 32'b0100);
    measure(nb, nh, nd, nm);
    check("s2_b_busy", nb, 61);
    check("s2_b_done", nd, 1);
    check("s2_onehot", nm, 0);
    wait_idle(10);

    // 3: zero-count request
    pulse(4'b1000, 16'h0000);
    @(negedge clk);
    check("s3_grant", {28'd0, grant}, 32'b1000);
    check("s3_flags", {29'd0, busy, done, beep}, 32'b110);
    measure(nb, nh, nd, nm);
    check("s3_busy", nb, 1);
    check("s3_high", nh, 0);
    wait_idle(10);

    // 4: re-request mid-burst (count overwrite only) and in the DONE cycle
    pulse(4'b0100, 16'h0300);
    @(negedge clk);
    check("s4_grant", {28'd0, grant}, 32'b0100);
    repeat (50) @(negedge clk);
    pulse(4'b0100, 16'h0500);
    repeat (127) @(negedge clk);
    check("s4_before_done", {30'd0, busy, done}, 32'b10);
    pulse(4'b0100, 16'h0300);
    check("s4_gap", {27'd0, grant, busy}, 0);
    @(negedge clk);
    check("s4_regrant", {28'd0, grant}, 32'b0100);
    measure(nb, nh, nd, nm);
    check("s4_busy", nb, 181);
    check("s4_high", nh, 60);
    check("s4_done", nd, 1);
    wait_idle(10);

    // 5: async reset mid-ON with another request pending
    pulse(4'b0010, 16'h0020);
    @(negedge clk);
    check("s5_grant", {28'd0, grant}, 32'b0010);
    repeat (10) @(negedge clk);
    pulse(4'b1000, 16'h0100);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("s5_async_clear", {25'd0, grant, busy, done, beep}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    check("s5_no_restart", nb, 0);

    // 6: requester 0 arrives during requester 2's burst
    do_reset();
    pulse(4'b0100, 16'h0100);
    @(negedge clk);
    check("s6_grant", {28'd0, grant}, 32'b0100);
    repeat (10) @(negedge clk);
    pulse(4'b0001, 16'h0001);
    measure(nb, nh, nd, nm);
`ifdef BEEP_PREEMPT_EN
    check("s6_abort_busy", nb, 1);
    check("s6_abort_done", nd, 0);
`else
    check("s6_rest_busy", nb, 49);
    check("s6_rest_done", nd, 1);
`endif
    check("s6_gap", {27'd0, grant, beep}, 0);
    @(negedge clk);
    check("s6_req0_grant", {28'd0, grant}, 32'b0001);
    measure(nb, nh, nd, nm);
    check("s6_req0_busy", nb, 61);
    check("s6_req0_done", nd, 1);
`ifdef BEEP_PREEMPT_EN
    @(negedge clk);
    check("s6_resume_grant", {28'd0, grant}, 32'b0100);
    measure(nb, nh, nd, nm);
    check("s6_resume_busy", nb, 61);
    check("s6_resume_high", nh, 20);
`endif
    wait_idle(10);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
